// File: rtl/sprite_pkg.sv
// Shared constants and types for the double-buffered sprite descriptor store.
// The optional macro SPRITE_AUTO_SWAP_EN is consumed by sprite_shadow_bank.
package sprite_pkg;

   localparam int NUM_SPRITES = 30;
   localparam int SPRITE_W    = 32;
   localparam int VBLANK_LINE = 480;
   localparam int ADDR_CLEAR  = 60;
   localparam int ADDR_SWAP   = 61;

   typedef logic [SPRITE_W-1:0] sprite_word_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COMMIT
   } bank_state_t;

endpackage

// File: rtl/vblank_edge_detect.sv
// Flags the first cycle of a frame in which vcount equals the vertical-blank line.
// A vcount stalled on that line yields a single flag.
module vblank_edge_detect #(
   parameter int VBLANK_LINE = sprite_pkg::VBLANK_LINE,
   parameter int VCOUNT_W    = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [VCOUNT_W-1:0] vcount,
   output logic                vb_edge
);
   import sprite_pkg::*;

   localparam logic [VCOUNT_W-1:0] LINE = VCOUNT_W'(VBLANK_LINE);

   logic [VCOUNT_W-1:0] vcount_q;
   logic [VCOUNT_W-1:0] vcount_d;

   always_comb begin
      vcount_d = vcount;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vcount_q <= '0;
      end else begin
         vcount_q <= vcount_d;
      end
   end

   assign vb_edge = (vcount == LINE) && (vcount_q != LINE);

endmodule

// File: rtl/sprite_shadow_bank.sv
// Double-buffered sprite descriptors: software writes a shadow bank, which is copied to
// the active bank at vblank entry once a swap is armed. Optional macro: SPRITE_AUTO_SWAP_EN.
module sprite_shadow_bank #(
   parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
   parameter int SPRITE_W    = sprite_pkg::SPRITE_W,
   parameter int ADDR_W      = 6,
   parameter int VBLANK_LINE = sprite_pkg::VBLANK_LINE
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [ADDR_W-1:0]               address,
   input  logic [SPRITE_W-1:0]             writedata,
   input  logic                            write,
   input  logic                            chipselect,
   input  logic [9:0]                      vcount,
   output logic [NUM_SPRITES*SPRITE_W-1:0] sprite_active,
   output logic                            commit_pulse,
   output logic                            swap_armed,
   output logic [15:0]                     frame_count
);
   import sprite_pkg::*;

   localparam logic [ADDR_W-1:0] A_CLEAR = ADDR_W'(ADDR_CLEAR);
   localparam logic [ADDR_W-1:0] A_SWAP  = ADDR_W'(ADDR_SWAP);

   bank_state_t                     state_q, state_d;
   logic [SPRITE_W-1:0]             shadow_q [NUM_SPRITES];
   logic [SPRITE_W-1:0]             shadow_d [NUM_SPRITES];
   logic [NUM_SPRITES*SPRITE_W-1:0] active_q, active_d;
   logic [NUM_SPRITES*SPRITE_W-1:0] shadow_flat;
   logic [15:0]                     frame_count_q, frame_count_d;

   logic vb_edge;
   logic wr_en;
   logic wr_word;
   logic wr_clear;
   logic wr_swap;
   logic arm_req;

   vblank_edge_detect #(
      .VBLANK_LINE (VBLANK_LINE),
      .VCOUNT_W    (10)
   ) u_vblank_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .vcount  (vcount),
      .vb_edge (vb_edge)
   );

   assign wr_en    = write & chipselect;
   assign wr_clear = wr_en && (address == A_CLEAR);
   assign wr_swap  = wr_en && (address == A_SWAP);

`ifdef SPRITE_AUTO_SWAP_EN
   assign arm_req = wr_swap | wr_word | wr_clear;
`else
   assign arm_req = wr_swap;
`endif

   always_comb begin
      wr_word = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_d[i] = wr_clear ? '0 : shadow_q[i];
         if (wr_en && (address == ADDR_W'(i))) begin
            shadow_d[i] = writedata;
            wr_word     = 1'b1;
         end
      end
   end

   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_flat[i*SPRITE_W +: SPRITE_W] = shadow_q[i];
      end
   end

   // The copy samples shadow_q, so a write or CLEAR landing in the same cycle only
   // affects the shadow and waits for the next swap.
   always_comb begin
      state_d       = state_q;
      active_d      = active_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE: begin
            if (arm_req) state_d = ARMED;
         end
         ARMED: begin
            if (vb_edge) begin
               state_d       = COMMIT;
               active_d      = shadow_flat;
               frame_count_d = frame_count_q + 16'd1;
            end
         end
         COMMIT: begin
            state_d = arm_req ? ARMED : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         active_q      <= '0;
         frame_count_q <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         active_q      <= active_d;
         frame_count_q <= frame_count_d;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign sprite_active = active_q;
   assign commit_pulse  = (state_q == COMMIT);
   assign swap_armed    = (state_q == ARMED);
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_sprite_shadow_bank.sv
// Bench for sprite_shadow_bank: directed vector table, corner-case sequences and
// randomized traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_sprite_shadow_bank;
   import sprite_pkg::*;

   localparam int NS = NUM_SPRITES;
   localparam int SW = SPRITE_W;
   localparam int AW = 6;
`ifdef SPRITE_AUTO_SWAP_EN
   localparam logic AUTO = 1'b1;
`else
   localparam logic AUTO = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [AW-1:0]    address = '0;
   logic [SW-1:0]    writedata = '0;
   logic             write = 1'b0;
   logic             chipselect = 1'b0;
   logic [9:0]       vcount = '0;
   logic [NS*SW-1:0] sprite_active;
   logic             commit_pulse;
   logic             swap_armed;
   logic [15:0]      frame_count;

   sprite_shadow_bank dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .writedata     (writedata),
      .write         (write),
      .chipselect    (chipselect),
      .vcount        (vcount),
      .sprite_active (sprite_active),
      .commit_pulse  (commit_pulse),
      .swap_armed    (swap_armed),
      .frame_count   (frame_count)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;

   sprite_word_t m_shadow [NS];
   sprite_word_t m_active [NS];
   logic         m_armed;
   logic         m_pulse;
   logic [15:0]  m_frame;
   logic [9:0]   m_vq;

   typedef struct {
      logic        wr;
      logic        cs;
      logic [5:0]  a;
      logic [31:0] d;
      logic [9:0]  vc;
      int          idx;
      logic [31:0] w;
      logic        p;
      logic        arm;
      logic [15:0] fc;
   } vec_t;

   vec_t tbl [12];

   function automatic logic [31:0] aw(input int i);
      return sprite_active[i*SW +: SW];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_armed = 1'b0;
      m_pulse = 1'b0;
      m_frame = '0;
      m_vq    = '0;
   endtask

   // Frame-level rules: a commit happens at vblank entry if armed; it copies the
   // shadow as it stood before this cycle's write and disarms.
   task automatic model_clock();
      logic en, is_word, is_clear, is_swap, edge_now, commit, arm;
      en       = write && chipselect;
      is_word  = en && (int'(address) < NS);
      is_clear = en && (int'(address) == ADDR_CLEAR);
      is_swap  = en && (int'(address) == ADDR_SWAP);
      edge_now = (int'(vcount) == VBLANK_LINE) && (int'(m_vq) != VBLANK_LINE);
      commit   = m_armed && edge_now && !m_pulse;
      arm      = is_swap || (AUTO && (is_word || is_clear));
      if (commit) begin
         m_active = m_shadow;
         m_frame  = m_frame + 16'd1;
      end
      if (commit) m_armed = 1'b0;
      else if (arm) m_armed = 1'b1;
      m_pulse = commit;
      if (is_clear) begin
         for (int i = 0; i < NS; i++) m_shadow[i] = '0;
      end
      if (is_word) m_shadow[int'(address)] = writedata;
      m_vq = vcount;
   endtask

   task automatic check_model(input string tag);
      int badw;
      badw = -1;
      for (int i = 0; i < NS; i++) begin
         if (aw(i) !== m_active[i] && badw < 0) badw = i;
      end
      total++;
      if (badw >= 0) begin
         bad++;
         $display("FAIL %s active word %0d: got %h want %h", tag, badw, aw(badw), m_active[badw]);
      end
      check({tag, " pulse"}, 64'(commit_pulse), 64'(m_pulse));
      check({tag, " armed"}, 64'(swap_armed), 64'(m_armed));
      check({tag, " frames"}, 64'(frame_count), 64'(m_frame));
   endtask

   task automatic step(input logic wr, input logic cs, input logic [AW-1:0] a,
                       input logic [SW-1:0] d, input logic [9:0] vc);
      write      = wr;
      chipselect = cs;
      address    = a;
      writedata  = d;
      vcount     = vc;
      @(posedge clk);
      model_clock();
      #1;
      check_model("model");
   endtask

   task automatic idle(input logic [9:0] vc);
      step(1'b0, 1'b0, '0, '0, vc);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [SW-1:0] d, input logic [9:0] vc);
      step(1'b1, 1'b1, a, d, vc);
   endtask

   task automatic to_vblank();
      idle(10'd0);
      idle(10'd479);
      idle(10'd480);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset word0", 64'(aw(0)), 64'h0);
      check("reset pulse", 64'(commit_pulse), 64'h0);
      check("reset armed", 64'(swap_armed), 64'h0);
      check("reset frames", 64'(frame_count), 64'h0);
      reset_n = 1'b1;

      tbl[0]  = '{1'b1, 1'b1, 6'd0,  32'h12345678, 10'd479, 0, 32'h0, 1'b0, AUTO, 16'd0};
      tbl[1]  = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd480, 0, AUTO ? 32'h12345678 : 32'h0, AUTO, 1'b0, 16'(AUTO)};
      tbl[2]  = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd481, 0, AUTO ? 32'h12345678 : 32'h0, 1'b0, 1'b0, 16'(AUTO)};
      tbl[3]  = '{1'b1, 1'b1, 6'd3,  32'hA5A5A5A5, 10'd0, 3, 32'h0, 1'b0, AUTO, 16'(AUTO)};
      tbl[4]  = '{1'b1, 1'b1, 6'd61, 32'hFFFFFFFF, 10'd0, 3, 32'h0, 1'b0, 1'b1, 16'(AUTO)};
      tbl[5]  = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd479, 3, 32'h0, 1'b0, 1'b1, 16'(AUTO)};
      tbl[6]  = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd480, 3, 32'hA5A5A5A5, 1'b1, 1'b0, 16'(AUTO) + 16'd1};
      tbl[7]  = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd480, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 16'(AUTO) + 16'd1};
      tbl[8]  = '{1'b1, 1'b1, 6'd62, 32'hFFFFFFFF, 10'd481, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 16'(AUTO) + 16'd1};
      tbl[9]  = '{1'b1, 1'b0, 6'd61, 32'h0, 10'd0, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 16'(AUTO) + 16'd1};
      tbl[10] = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd479, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 16'(AUTO) + 16'd1};
      tbl[11] = '{1'b0, 1'b0, 6'd0,  32'h0, 10'd480, 3, 32'hA5A5A5A5, 1'b0, 1'b0, 16'(AUTO) + 16'd1};

      for (int r = 0; r < 12; r++) begin
         step(tbl[r].wr, tbl[r].cs, tbl[r].a, tbl[r].d, tbl[r].vc);
         check($sformatf("vec%0d word%0d", r, tbl[r].idx), 64'(aw(tbl[r].idx)), 64'(tbl[r].w));
         check($sformatf("vec%0d pulse", r), 64'(commit_pulse), 64'(tbl[r].p));
         check($sformatf("vec%0d armed", r), 64'(swap_armed), 64'(tbl[r].arm));
         check($sformatf("vec%0d frames", r), 64'(frame_count), 64'(tbl[r].fc));
      end

      // SWAP coinciding with vblank entry while idle: arms, commits one frame later.
      idle(10'd0);
      idle(10'd479);
      wr(6'd61, 32'h0, 10'd480);
      check("swap_at_edge armed", 64'(swap_armed), 64'h1);
      check("swap_at_edge pulse", 64'(commit_pulse), 64'h0);
      for (int k = 0; k < 3; k++) begin
         idle(10'd480);
         check($sformatf("stall%0d pulse", k), 64'(commit_pulse), 64'h0);
      end
      to_vblank();
      check("next_frame pulse", 64'(commit_pulse), 64'h1);
      check("next_frame frames", 64'(frame_count), 64'(16'(AUTO) + 16'd2));
      idle(10'd480);
      check("pulse one cycle", 64'(commit_pulse), 64'h0);

      // Shadow write in the commit cycle stays in shadow until the next swap.
      wr(6'd5, 32'h1, 10'd0);
      wr(6'd61, 32'h0, 10'd0);
      idle(10'd479);
      idle(10'd480);
      check("w5 pre pulse", 64'(commit_pulse), 64'h1);
      wr(6'd5, 32'hDEADBEEF, 10'd480);
      check("w5 old value", 64'(aw(5)), 64'h1);
      wr(6'd61, 32'h0, 10'd481);
      to_vblank();
      check("w5 new value", 64'(aw(5)), 64'hDEADBEEF);

      // SWAP in the commit cycle re-arms for the next frame.
      wr(6'd61, 32'h0, 10'd0);
      idle(10'd479);
      idle(10'd480);
      wr(6'd61, 32'h0, 10'd480);
      check("swap_in_commit armed", 64'(swap_armed), 64'h1);
      to_vblank();
      check("swap_in_commit recommit", 64'(commit_pulse), 64'h1);

      // Populate, commit, then CLEAR + SWAP clears the whole active bank.
      for (int i = 0; i < NS; i++) wr(AW'(i), 32'(i + 1) | 32'h8000_0000, 10'd0);
      wr(6'd61, 32'h0, 10'd0);
      to_vblank();
      check("populated word17", 64'(aw(17)), 64'h8000_0012);
      wr(6'd60, 32'hFFFFFFFF, 10'd0);
      wr(6'd61, 32'h0, 10'd0);
      to_vblank();
      for (int i = 0; i < NS; i++) check($sformatf("cleared word%0d", i), 64'(aw(i)), 64'h0);

      // Asynchronous reset landing in the commit cycle.
      for (int i = 0; i < NS; i++) wr(AW'(i), 32'hC0DE_0000 + 32'(i), 10'd0);
      wr(6'd61, 32'h0, 10'd0);
      idle(10'd479);
      idle(10'd480);
      check("pre_reset pulse", 64'(commit_pulse), 64'h1);
      reset_n = 1'b0;
      #4;
      for (int i = 0; i < NS; i++) check($sformatf("async_reset word%0d", i), 64'(aw(i)), 64'h0);
      check("async_reset pulse", 64'(commit_pulse), 64'h0);
      check("async_reset armed", 64'(swap_armed), 64'h0);
      check("async_reset frames", 64'(frame_count), 64'h0);
      model_reset();
      #2;
      reset_n = 1'b1;
      idle(10'd0);
      idle(10'd479);
      idle(10'd480);
      check("post_reset no commit", 64'(aw(0)), 64'h0);

      // Plain shadow write without SWAP: commits only with auto-swap.
      wr(6'd29, 32'h00FF00FF, 10'd0);
      idle(10'd479);
      idle(10'd480);
      check("auto word29", 64'(aw(29)), AUTO ? 64'h00FF00FF : 64'h0);
      check("auto pulse", 64'(commit_pulse), 64'(AUTO));

      for (int c = 0; c < 3000; c++) begin
         logic [9:0]    vc;
         logic [AW-1:0] a;
         int            r;
         case ($urandom_range(0, 5))
            0: vc = 10'd0;
            1: vc = 10'd478;
            2: vc = 10'd479;
            3: vc = 10'd480;
            4: vc = 10'd480;
            default: vc = 10'd481;
         endcase
         r = $urandom_range(0, 9);
         if (r <= 5) a = AW'($urandom_range(0, NS - 1));
         else if (r == 7) a = ($urandom_range(0, 15) == 0) ? 6'd60 : 6'd61;
         else if (r == 8) a = AW'($urandom_range(30, 63));
         else a = 6'd61;
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), a, 32'($urandom), vc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_shadow_bank.md
Name: sprite_shadow_bank

Overview:
- Double-buffered sprite descriptor store between the Avalon slave write path and the sprite controller / VGA emulator.
- Software writes go to a shadow bank. The active bank seen by the sprite controller is updated only at vertical-blank entry, and only after software arms a swap.
- This removes mid-frame tearing of sprite position and ID words.

Parameters:
- NUM_SPRITES, 30, number of 32-bit sprite descriptor words.
- SPRITE_W, 32, descriptor width in bits.
- ADDR_W, 6, Avalon word-address width (must reach the command addresses 60/61).
- VBLANK_LINE, 480, vcount value whose first occurrence in a frame triggers a commit.

Ports:
- clk  in  1  system clock (50 MHz), same clock as the Avalon slave.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  Avalon word address.
- writedata  in  SPRITE_W  Avalon write data.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon chip select.
- vcount  in  10  current VGA line, from the VGA timing generator, synchronous to clk.
- sprite_active  out  NUM_SPRITES*SPRITE_W  flattened active bank; word i is at bits [i*SPRITE_W +: SPRITE_W].
- commit_pulse  out  1  one-cycle pulse in the cycle after the active bank updates.
- swap_armed  out  1  swap requested, not yet committed.
- frame_count  out  16  number of commits since reset; wraps 0xFFFF->0.

Behaviour:
- Reset is asynchronous, active-low, and effective mid-operation.
  - On reset: shadow and active banks = 0, swap_armed = 0, commit_pulse = 0, frame_count = 0, vblank edge register = 0.
- Write decode, qualified by write && chipselect:
  - address 0..NUM_SPRITES-1: shadow[address] <= writedata.
  - address 60 (CLEAR): all shadow words <= 0. Active bank is untouched.
  - address 61 (SWAP): swap_armed <= 1. writedata is ignored.
  - All other addresses: no effect.
- Vblank edge detection:
  - vb_edge = (vcount == VBLANK_LINE) && (vcount_q != VBLANK_LINE).
  - vcount_q is vcount registered once.
- State machine states:
  - IDLE (swap_armed=0): vb_edge is ignored.
  - ARMED (swap_armed=1): on vb_edge, enter COMMIT.
  - COMMIT: lasts one cycle. active <= shadow, swap_armed <= 0, frame_count <= frame_count+1. Next state is IDLE.
- Latency:
  - active bank updates on the clock edge after vb_edge is sampled in ARMED.
  - commit_pulse is high for exactly the following cycle.
- Simultaneous events:
  - Shadow write in the COMMIT copy cycle: active gets the pre-write shadow value; the new write stays in shadow for the next swap.
  - CLEAR in the COMMIT copy cycle: active gets the pre-clear shadow; shadow then reads all zero.
  - SWAP write in the same cycle as vb_edge while IDLE: becomes armed but does not commit this frame; it commits at the next frame's vb_edge.
  - SWAP write while already ARMED: no additional effect (idempotent).
  - SWAP write in the COMMIT cycle: swap_armed ends at 1 (the set wins over the clear); the next frame commits again.
- Stalled timing: vcount held at VBLANK_LINE produces only one vb_edge.
- Reset mid-COMMIT: all state returns to reset values; no partial copy remains after reset release.

Optional Feature:
- Macro: SPRITE_AUTO_SWAP_EN.
- Defined: any shadow write or CLEAR also sets swap_armed, so every modified frame commits at the next vblank without a SWAP write. SWAP still works.
- Undefined: only an address-61 write arms a swap.

Decomposition:
- Package sprite_pkg holds:
  - NUM_SPRITES, SPRITE_W, VBLANK_LINE.
  - ADDR_CLEAR = 60, ADDR_SWAP = 61.
  - typedef sprite_word_t (logic [SPRITE_W-1:0]).
  - enum bank_state_t {IDLE, ARMED, COMMIT}.
- One sub-module: vblank_edge_detect (registers vcount, outputs vb_edge). The sprite controller reuses it.

Test Plan:
- Reset, write shadow[0] = 0x12345678, no SWAP, run past vcount 480 -> sprite_active word0 = 0, commit_pulse never asserts, frame_count = 0.
- Write shadow[3] = 0xA5A5A5A5, write SWAP, drive vcount 479->480 -> word3 = 0xA5A5A5A5 one cycle after the edge, commit_pulse high 1 cycle, frame_count = 1, swap_armed = 0.
- SWAP written in the same cycle vcount reaches 480 -> no commit; commit occurs at the next frame's 479->480, frame_count 0->1.
- Write shadow[5] = 0xDEADBEEF in the COMMIT cycle with shadow[5] previously 0x1 -> active word5 = 0x1; after a second SWAP and vblank, word5 = 0xDEADBEEF.
- CLEAR + SWAP after populating words 0..29 with nonzero values -> all 30 active words = 0 after the next vblank; reset_n pulsed low mid-frame -> all outputs 0 immediately (asynchronously).
- With SPRITE_AUTO_SWAP_EN: write shadow[29] = 0x00FF00FF, no SWAP, vblank -> word29 = 0x00FF00FF, frame_count increments. Without the macro: word29 stays 0.
